// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Control unit for a small multicycle CPU.
//               - Single-cycle instructions are decoded combinationally in
//                 FETCH and the FSM stays in FETCH.
//               - ld/st move to MEM and wait for mem_ack. ld then takes one
//                 WB cycle that writes memory data to the register file.
//               - An undefined opcode pulses illegal for one cycle and is
//                 executed as a NOP.
// Ports       : clk          rising-edge clock
//               reset        asynchronous, active-low reset
//               opcode       instruction opcode (OPCODE_W bits)
//               instr_valid  an instruction is present this cycle
//               mem_ack      data-memory acknowledge
//               alu_op, alu_src, b_src, ext_sel, wb_src[2:0], reg_write,
//               nz_update, pc_src, br_src, br_cond[1:0], pc_enable        -
//                            datapath controls
//               mem_req, mem_we, mem_sel  data-memory controls
//               busy         multicycle operation in progress
//               illegal      one-cycle pulse on an undefined opcode
//               mem_err      sticky memory-timeout flag
// Config      : `define MULTICYCLE_CTRL_TIMEOUT_EN adds a wait counter and an
//               ERR state. A MEM access that waits TIMEOUT_CYCLES cycles
//               without mem_ack then stops in ERR until reset. When the macro
//               is not defined, MEM waits without limit and mem_err is
//               tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
  parameter int OPCODE_W       = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                instr_valid,
  input  logic                mem_ack,
  output logic                alu_op,
  output logic                alu_src,
  output logic                b_src,
  output logic                ext_sel,
  output logic [2:0]          wb_src,
  output logic                reg_write,
  output logic                nz_update,
  output logic                pc_src,
  output logic                br_src,
  output logic [1:0]          br_cond,
  output logic                pc_enable,
  output logic                mem_req,
  output logic                mem_we,
  output logic                mem_sel,
  output logic                busy,
  output logic                illegal,
  output logic                mem_err
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] C_ST_IDLE  = 3'd0;
  localparam logic [2:0] C_ST_FETCH = 3'd1;
  localparam logic [2:0] C_ST_MEM   = 3'd2;
  localparam logic [2:0] C_ST_WB    = 3'd3;
  localparam logic [2:0] C_ST_ERR   = 3'd4;

  // --------------------------------------------------------------------------
  // Opcodes (low five bits; any higher opcode bit set makes it illegal)
  // --------------------------------------------------------------------------
  localparam logic [4:0] C_OP_MV   = 5'b00000;
  localparam logic [4:0] C_OP_ADD  = 5'b00001;
  localparam logic [4:0] C_OP_SUB  = 5'b00010;
  localparam logic [4:0] C_OP_CMP  = 5'b00011;
  localparam logic [4:0] C_OP_LD   = 5'b00100;
  localparam logic [4:0] C_OP_ST   = 5'b00101;
  localparam logic [4:0] C_OP_JR   = 5'b01000;
  localparam logic [4:0] C_OP_JZR  = 5'b01001;
  localparam logic [4:0] C_OP_JNR  = 5'b01010;
  localparam logic [4:0] C_OP_MVI  = 5'b10000;
  localparam logic [4:0] C_OP_ADDI = 5'b10001;
  localparam logic [4:0] C_OP_SUBI = 5'b10010;
  localparam logic [4:0] C_OP_CMPI = 5'b10011;
  localparam logic [4:0] C_OP_MVHI = 5'b10110;
  localparam logic [4:0] C_OP_J    = 5'b11000;
  localparam logic [4:0] C_OP_JZ   = 5'b11001;
  localparam logic [4:0] C_OP_JN   = 5'b11010;

  // Write-back source selects
  localparam logic [2:0] C_WB_MEM  = 3'b000;
  localparam logic [2:0] C_WB_ALU  = 3'b001;
  localparam logic [2:0] C_WB_RY   = 3'b011;
  localparam logic [2:0] C_WB_IMM8 = 3'b100;
  localparam logic [2:0] C_WB_HI   = 3'b101;

  // Branch conditions
  localparam logic [1:0] C_BR_ALWAYS = 2'b00;
  localparam logic [1:0] C_BR_Z      = 2'b01;
  localparam logic [1:0] C_BR_N      = 2'b10;

  // --------------------------------------------------------------------------
  // Registers and wires
  // --------------------------------------------------------------------------
  logic [2:0] r_state;
  logic [2:0] w_state_nxt;
  logic [4:0] r_op;          // ld/st opcode held for the whole access
  logic [4:0] w_op_lo;
  logic       w_hi_nz;       // any opcode bit above bit 4 is set
  logic       w_mem_start;   // FETCH -> MEM transition this cycle
  logic       w_timeout;

  // Decoder outputs, used only in FETCH
  logic       w_d_legal;
  logic       w_d_is_mem;
  logic       w_d_alu_op;
  logic       w_d_alu_src;
  logic       w_d_b_src;
  logic       w_d_ext_sel;
  logic [2:0] w_d_wb_src;
  logic       w_d_reg_write;
  logic       w_d_nz_update;
  logic       w_d_pc_src;
  logic       w_d_br_src;
  logic [1:0] w_d_br_cond;
  logic       w_d_pc_enable;

  assign w_op_lo     = opcode[4:0];
  assign w_mem_start = (r_state == C_ST_FETCH) && (w_state_nxt == C_ST_MEM);

  generate
    if (OPCODE_W > 5) begin : g_hi_bits
      assign w_hi_nz = |opcode[OPCODE_W-1:5];
    end else begin : g_no_hi_bits
      assign w_hi_nz = 1'b0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Memory wait counter and sticky error flag
  // --------------------------------------------------------------------------
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
  localparam int               CNT_W          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT      = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_mem_err;

  // The cycle that brings the counter to TIMEOUT_CYCLES is the last MEM
  // cycle. An access without ack therefore spends exactly TIMEOUT_CYCLES
  // cycles in MEM.
  assign w_timeout = (r_state == C_ST_MEM) && !mem_ack &&
                     (r_wait_cnt == C_TIMEOUT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      if (w_mem_start) begin
        r_wait_cnt <= '0;
      end else if ((r_state == C_ST_MEM) && !mem_ack &&
                   (r_wait_cnt != C_TIMEOUT)) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_timeout) begin
        r_mem_err <= 1'b1;
      end
    end
  end

  assign mem_err = r_mem_err;
`else
  // TIMEOUT_CYCLES has no effect when the timeout feature is left out.
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES != 0);
  assign w_timeout    = 1'b0;
  assign mem_err      = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Instruction decoder
  // --------------------------------------------------------------------------
  always_comb begin
    w_d_legal     = 1'b1;
    w_d_is_mem    = 1'b0;
    w_d_alu_op    = 1'b0;
    w_d_alu_src   = 1'b0;
    w_d_b_src     = 1'b0;
    w_d_ext_sel   = 1'b0;
    w_d_wb_src    = C_WB_ALU;
    w_d_reg_write = 1'b0;
    w_d_nz_update = 1'b0;
    w_d_pc_src    = 1'b1;
    w_d_br_src    = 1'b0;
    w_d_br_cond   = C_BR_ALWAYS;
    w_d_pc_enable = 1'b0;
    case (w_op_lo)
      C_OP_MV: begin
        w_d_reg_write = 1'b1;
        w_d_wb_src    = C_WB_RY;
      end
      C_OP_ADD: begin
        w_d_reg_write = 1'b1;
      end
      C_OP_SUB: begin
        w_d_reg_write = 1'b1;
        w_d_alu_op    = 1'b1;
      end
      C_OP_CMP: begin
        w_d_nz_update = 1'b1;
        w_d_alu_op    = 1'b1;
      end
      C_OP_MVI: begin
        w_d_reg_write = 1'b1;
        w_d_wb_src    = C_WB_IMM8;
      end
      C_OP_ADDI: begin
        w_d_reg_write = 1'b1;
        w_d_nz_update = 1'b1;
        w_d_alu_src   = 1'b1;
        w_d_b_src     = 1'b1;
      end
      C_OP_SUBI: begin
        w_d_reg_write = 1'b1;
        w_d_nz_update = 1'b1;
        w_d_alu_op    = 1'b1;
        w_d_alu_src   = 1'b1;
        w_d_b_src     = 1'b1;
      end
      C_OP_CMPI: begin
        w_d_nz_update = 1'b1;
        w_d_alu_op    = 1'b1;
        w_d_alu_src   = 1'b1;
        w_d_b_src     = 1'b1;
      end
      C_OP_MVHI: begin
        w_d_reg_write = 1'b1;
        w_d_wb_src    = C_WB_HI;
      end
      C_OP_JR, C_OP_JZR, C_OP_JNR, C_OP_J, C_OP_JZ, C_OP_JN: begin
        w_d_pc_src    = 1'b0;
        w_d_pc_enable = 1'b1;
        w_d_ext_sel   = 1'b1;
        // Bit 4 separates immediate targets from register targets.
        w_d_br_src    = w_op_lo[4];
        // The low two bits select always / Z / N in both jump groups.
        w_d_br_cond   = w_op_lo[1:0];
      end
      C_OP_LD, C_OP_ST: begin
        w_d_is_mem = 1'b1;
      end
      default: begin
        w_d_legal = 1'b0;
      end
    endcase
    if (w_hi_nz) begin
      w_d_legal = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    alu_op      = 1'b0;
    alu_src     = 1'b0;
    b_src       = 1'b0;
    ext_sel     = 1'b0;
    wb_src      = C_WB_MEM;
    reg_write   = 1'b0;
    nz_update   = 1'b0;
    pc_src      = 1'b1;
    br_src      = 1'b0;
    br_cond     = C_BR_ALWAYS;
    pc_enable   = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_sel     = 1'b0;
    busy        = 1'b0;
    illegal     = 1'b0;
    case (r_state)
      C_ST_IDLE: begin
        w_state_nxt = C_ST_FETCH;
      end
      C_ST_FETCH: begin
        if (instr_valid) begin
          if (!w_d_legal) begin
            // Executed as a NOP. The defaults already keep every enable low.
            illegal = 1'b1;
          end else if (w_d_is_mem) begin
            w_state_nxt = C_ST_MEM;
          end else begin
            alu_op    = w_d_alu_op;
            alu_src   = w_d_alu_src;
            b_src     = w_d_b_src;
            ext_sel   = w_d_ext_sel;
            wb_src    = w_d_wb_src;
            reg_write = w_d_reg_write;
            nz_update = w_d_nz_update;
            pc_src    = w_d_pc_src;
            br_src    = w_d_br_src;
            br_cond   = w_d_br_cond;
            pc_enable = w_d_pc_enable;
          end
        end
      end
      C_ST_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        busy    = 1'b1;
        mem_we  = (r_op == C_OP_ST);
        if (mem_ack) begin
          w_state_nxt = (r_op == C_OP_LD) ? C_ST_WB : C_ST_FETCH;
        end else if (w_timeout) begin
          w_state_nxt = C_ST_ERR;
        end
      end
      C_ST_WB: begin
        reg_write   = 1'b1;
        wb_src      = C_WB_MEM;
        busy        = 1'b1;
        w_state_nxt = C_ST_FETCH;
      end
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
      C_ST_ERR: begin
        // Only reset leaves this state.
        busy = 1'b1;
      end
`endif
      default: begin
        w_state_nxt = C_ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and latched opcode
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= C_ST_IDLE;
      r_op    <= 5'b00000;
    end else begin
      r_state <= w_state_nxt;
      if (w_mem_start) begin
        r_op <= w_op_lo;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Self-checking bench for multicycle_ctrl. Directed and random
//               instruction streams are compared against a table-driven
//               model of the opcode rules and the memory access sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  localparam int OW = 7;
  localparam int TO = 4;

  localparam logic [OW-1:0] OP_ADD = 7'b0000001;
  localparam logic [OW-1:0] OP_LD  = 7'b0000100;
  localparam logic [OW-1:0] OP_ST  = 7'b0000101;

  localparam logic [OW-1:0] LEGAL_OPS [15] = '{
    7'b0000000, 7'b0000001, 7'b0000010, 7'b0000011, 7'b0010000,
    7'b0010001, 7'b0010010, 7'b0010011, 7'b0010110, 7'b0001000,
    7'b0001001, 7'b0001010, 7'b0011000, 7'b0011001, 7'b0011010};

  typedef struct packed {
    logic       alu_op;
    logic       alu_src;
    logic       b_src;
    logic       ext_sel;
    logic [2:0] wb_src;
    logic       reg_write;
    logic       nz_update;
    logic       pc_src;
    logic       br_src;
    logic [1:0] br_cond;
    logic       pc_enable;
    logic       mem_req;
    logic       mem_we;
    logic       mem_sel;
    logic       busy;
    logic       illegal;
    logic       mem_err;
  } ctl_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [OW-1:0] opcode = '0;
  logic          instr_valid = 1'b0;
  logic          mem_ack = 1'b0;
  logic          alu_op, alu_src, b_src, ext_sel, reg_write, nz_update;
  logic          pc_src, br_src, pc_enable, mem_req, mem_we, mem_sel;
  logic          busy, illegal, mem_err;
  logic [2:0]    wb_src;
  logic [1:0]    br_cond;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.OPCODE_W(OW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .instr_valid(instr_valid),
    .mem_ack(mem_ack), .alu_op(alu_op), .alu_src(alu_src), .b_src(b_src),
    .ext_sel(ext_sel), .wb_src(wb_src), .reg_write(reg_write),
    .nz_update(nz_update), .pc_src(pc_src), .br_src(br_src),
    .br_cond(br_cond), .pc_enable(pc_enable), .mem_req(mem_req),
    .mem_we(mem_we), .mem_sel(mem_sel), .busy(busy), .illegal(illegal),
    .mem_err(mem_err));

  function automatic ctl_t sample();
    ctl_t s;
    s.alu_op = alu_op;       s.alu_src = alu_src;     s.b_src = b_src;
    s.ext_sel = ext_sel;     s.wb_src = wb_src;       s.reg_write = reg_write;
    s.nz_update = nz_update; s.pc_src = pc_src;       s.br_src = br_src;
    s.br_cond = br_cond;     s.pc_enable = pc_enable; s.mem_req = mem_req;
    s.mem_we = mem_we;       s.mem_sel = mem_sel;     s.busy = busy;
    s.illegal = illegal;     s.mem_err = mem_err;
    return s;
  endfunction

  // Reset / IDLE: every output low except pc_src.
  function automatic ctl_t idle_exp();
    ctl_t e = '0;
    e.pc_src = 1'b1;
    return e;
  endfunction

  // Expected FETCH-cycle behaviour from the opcode table. kind: 0 = stays in
  // FETCH, 1 = ld, 2 = st.
  function automatic void model_fetch(input logic v, input logic [OW-1:0] op,
                                      output ctl_t e, output ctl_t m,
                                      output int kind);
    bit alu = 0, jmp = 0;
    e = '0;
    e.pc_src = 1'b1;
    m = '0;
    m.reg_write = 1; m.nz_update = 1; m.pc_src = 1; m.mem_req = 1;
    m.mem_sel = 1; m.illegal = 1; m.mem_err = 1; m.busy = 1;
    kind = 0;
    if (!v) begin
      m.pc_enable = 1;
      return;
    end
    case (op)
      7'b0000000: begin e.reg_write = 1; e.wb_src = 3'b011; end
      7'b0000001: begin e.reg_write = 1; e.wb_src = 3'b001; alu = 1; end
      7'b0000010: begin e.reg_write = 1; e.wb_src = 3'b001; alu = 1; e.alu_op = 1; end
      7'b0000011: begin e.nz_update = 1; alu = 1; e.alu_op = 1; end
      7'b0010000: begin e.reg_write = 1; e.wb_src = 3'b100; end
      7'b0010001: begin e.reg_write = 1; e.nz_update = 1; e.wb_src = 3'b001;
                        alu = 1; e.alu_src = 1; e.b_src = 1; end
      7'b0010010: begin e.reg_write = 1; e.nz_update = 1; e.wb_src = 3'b001;
                        alu = 1; e.alu_op = 1; e.alu_src = 1; e.b_src = 1; end
      7'b0010011: begin e.nz_update = 1; alu = 1; e.alu_op = 1;
                        e.alu_src = 1; e.b_src = 1; end
      7'b0010110: begin e.reg_write = 1; e.wb_src = 3'b101; end
      7'b0001000: begin jmp = 1; e.br_cond = 2'b00; end
      7'b0001001: begin jmp = 1; e.br_cond = 2'b01; end
      7'b0001010: begin jmp = 1; e.br_cond = 2'b10; end
      7'b0011000: begin jmp = 1; e.br_src = 1; e.br_cond = 2'b00; end
      7'b0011001: begin jmp = 1; e.br_src = 1; e.br_cond = 2'b01; end
      7'b0011010: begin jmp = 1; e.br_src = 1; e.br_cond = 2'b10; end
      7'b0000100: kind = 1;
      7'b0000101: kind = 2;
      default:    begin e.illegal = 1; m.pc_enable = 1; end
    endcase
    if (jmp) begin
      e.pc_src = 0; e.pc_enable = 1; e.ext_sel = 1;
      m.pc_enable = 1; m.ext_sel = 1; m.br_src = 1; m.br_cond = 2'b11;
    end
    if (alu) begin
      m.alu_op = 1; m.alu_src = 1; m.b_src = 1;
    end
    if (e.reg_write) m.wb_src = 3'b111;
    if (kind != 0) m.busy = 0;
  endfunction

  function automatic ctl_t mem_exp(input bit is_st);
    ctl_t e = '0;
    e.mem_req = 1; e.mem_sel = 1; e.busy = 1; e.mem_we = is_st;
    return e;
  endfunction

  function automatic ctl_t mem_mask();
    ctl_t m = '0;
    m.reg_write = 1; m.nz_update = 1; m.pc_enable = 1; m.mem_req = 1;
    m.mem_we = 1; m.mem_sel = 1; m.busy = 1; m.illegal = 1; m.mem_err = 1;
    return m;
  endfunction

  function automatic ctl_t wb_exp();
    ctl_t e = '0;
    e.reg_write = 1; e.wb_src = 3'b000; e.busy = 1;
    return e;
  endfunction

  function automatic ctl_t wb_mask();
    ctl_t m = '0;
    m.reg_write = 1; m.wb_src = 3'b111; m.nz_update = 1; m.pc_enable = 1;
    m.mem_req = 1; m.busy = 1; m.illegal = 1; m.mem_err = 1;
    return m;
  endfunction

  // Drive one cycle's inputs after the falling edge and let outputs settle.
  task automatic apply(input logic v, input logic [OW-1:0] op, input logic ack);
    @(negedge clk);
    instr_valid = v;
    opcode      = op;
    mem_ack     = ack;
    #1;
  endtask

  // MEM wait cycles, the ack cycle and, for ld, the WB cycle. The FETCH cycle
  // that issued the access has already been checked.
  task automatic run_mem(input bit is_st, input int delay);
    ctl_t e, m, a;
    e = mem_exp(is_st);
    m = mem_mask();
    for (int i = 0; i < delay; i++) begin
      apply(1'($urandom), OW'($urandom), 1'b0);
      a = sample(); total++;
      if ((a & m) !== (e & m)) begin
        bad++; $display("FAIL mem_wait[%0d]: got %h want %h mask %h", i, a, e, m);
      end
    end
    apply(1'($urandom), OW'($urandom), 1'b1);
    a = sample(); total++;
    if ((a & m) !== (e & m)) begin
      bad++; $display("FAIL mem_ack_cycle: got %h want %h mask %h", a, e, m);
    end
    if (!is_st) begin
      apply(1'($urandom), OW'($urandom), 1'($urandom));
      e = wb_exp(); m = wb_mask(); a = sample(); total++;
      if ((a & m) !== (e & m)) begin
        bad++; $display("FAIL wb_cycle: got %h want %h mask %h", a, e, m);
      end
    end
  endtask

  task automatic test_reset();
    ctl_t e, m, a;
    int   kind;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, OW'($urandom), 1'b1);
      e = idle_exp(); a = sample(); total++;
      if (a !== e) begin
        bad++; $display("FAIL reset_hold: got %h want %h", a, e);
      end
    end
    @(negedge clk);
    reset = 1'b1; instr_valid = 1'b1; opcode = OP_ADD; mem_ack = 1'b0;
    #1;
    e = idle_exp(); a = sample(); total++;
    if (a !== e) begin
      bad++; $display("FAIL idle_after_release: got %h want %h", a, e);
    end
    apply(1'b0, OP_ADD, 1'b1);
    model_fetch(1'b0, OP_ADD, e, m, kind);
    a = sample(); total++;
    if ((a & m) !== (e & m)) begin
      bad++; $display("FAIL fetch_no_instr: got %h want %h", a, e);
    end
    apply(1'b1, OP_ADD, 1'b0);
    model_fetch(1'b1, OP_ADD, e, m, kind);
    a = sample(); total++;
    if ((a & m) !== (e & m)) begin
      bad++; $display("FAIL add_decode: got %h want %h", a, e);
    end
  endtask

  task automatic test_single();
    ctl_t e, m, a;
    int   kind;
    logic [OW-1:0] extra [3] = '{7'b0011111, 7'b0000111, 7'b0100100};
    for (int i = 0; i < 15; i++) begin
      apply(1'b1, LEGAL_OPS[i], 1'($urandom));
      model_fetch(1'b1, LEGAL_OPS[i], e, m, kind);
      a = sample(); total++;
      if ((a & m) !== (e & m)) begin
        bad++; $display("FAIL single_op %b: got %h want %h", LEGAL_OPS[i], a, e);
      end
    end
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, extra[i], 1'b1);
      model_fetch(1'b1, extra[i], e, m, kind);
      a = sample(); total++;
      if ((a & m) !== (e & m)) begin
        bad++; $display("FAIL illegal_op %b: got %h want %h", extra[i], a, e);
      end
    end
  endtask

  task automatic test_ld_wait3();
    ctl_t e, m, a;
    int   kind;
    apply(1'b1, OP_LD, 1'b0);
    model_fetch(1'b1, OP_LD, e, m, kind);
    a = sample(); total++;
    if ((a & m) !== (e & m)) begin
      bad++; $display("FAIL ld_issue: got %h want %h", a, e);
    end
    run_mem(1'b0, 3);
    apply(1'b0, OP_LD, 1'b1);
    model_fetch(1'b0, OP_LD, e, m, kind);
    a = sample(); total++;
    if ((a & m) !== (e & m)) begin
      bad++; $display("FAIL ld_back_to_fetch: got %h want %h", a, e);
    end
  endtask

  task automatic test_st_fast();
    ctl_t e, m, a;
    int   kind;
    apply(1'b1, OP_ST, 1'b0);
    model_fetch(1'b1, OP_ST, e, m, kind);
    a = sample(); total++;
    if ((a & m) !== (e & m)) begin
      bad++; $display("FAIL st_issue: got %h want %h", a, e);
    end
    run_mem(1'b1, 0);
    apply(1'b0, OP_ST, 1'b0);
    model_fetch(1'b0, OP_ST, e, m, kind);
    a = sample(); total++;
    if ((a & m) !== (e & m)) begin
      bad++; $display("FAIL st_back_to_fetch: got %h want %h", a, e);
    end
  endtask

  task automatic test_random();
    ctl_t e, m, a;
    int   kind, r;
    logic v;
    logic [OW-1:0] op;
    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(0, 99));
      v = 1'b1;
      if (r < 10) begin
        v = 1'b0; op = OW'($urandom);
      end else if (r < 20) op = OW'($urandom);
      else if (r < 30) op = {2'b00, 5'($urandom)};
      else if (r < 50) op = ($urandom_range(0, 1) != 0) ? OP_LD : OP_ST;
      else op = LEGAL_OPS[$urandom_range(0, 14)];
      apply(v, op, 1'($urandom));
      model_fetch(v, op, e, m, kind);
      a = sample(); total++;
      if ((a & m) !== (e & m)) begin
        bad++; $display("FAIL rand_fetch v=%b op=%b: got %h want %h", v, op, a, e);
      end
      if (kind != 0) run_mem(kind == 2, int'($urandom_range(0, TO - 1)));
    end
  endtask

  task automatic test_reset_mid_mem();
    ctl_t e, m, a;
    int   kind;
    apply(1'b1, OP_LD, 1'b0);
    apply(1'b0, OW'($urandom), 1'b0);
    e = mem_exp(1'b0); m = mem_mask(); a = sample(); total++;
    if ((a & m) !== (e & m)) begin
      bad++; $display("FAIL pre_reset_mem: got %h want %h", a, e);
    end
    #2 reset = 1'b0;
    #1;
    e = idle_exp(); a = sample(); total++;
    if (a !== e) begin
      bad++; $display("FAIL reset_mid_mem: got %h want %h", a, e);
    end
    apply(1'b1, OW'($urandom), 1'b1);
    @(negedge clk);
    reset = 1'b1; instr_valid = 1'b1; opcode = OP_ADD; mem_ack = 1'b1;
    #1;
    a = sample(); total++;
    if (a !== e) begin
      bad++; $display("FAIL idle_after_mid_reset: got %h want %h", a, e);
    end
    apply(1'b1, OP_ADD, 1'b0);
    model_fetch(1'b1, OP_ADD, e, m, kind);
    a = sample(); total++;
    if ((a & m) !== (e & m)) begin
      bad++; $display("FAIL fetch_after_mid_reset: got %h want %h", a, e);
    end
  endtask

  task automatic test_timeout();
    ctl_t e, m, a;
    int   kind;
    apply(1'b1, OP_LD, 1'b0);
    model_fetch(1'b1, OP_LD, e, m, kind);
    a = sample(); total++;
    if ((a & m) !== (e & m)) begin
      bad++; $display("FAIL to_ld_issue: got %h want %h", a, e);
    end
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
    e = mem_exp(1'b0); m = mem_mask();
    for (int i = 0; i < TO; i++) begin
      apply(1'b1, OW'($urandom), 1'b0);
      a = sample(); total++;
      if ((a & m) !== (e & m)) begin
        bad++; $display("FAIL to_mem_wait[%0d]: got %h want %h", i, a, e);
      end
    end
    e = '0; e.busy = 1; e.mem_err = 1;
    m = wb_mask(); m.wb_src = 3'b000;
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, OP_ADD, 1'($urandom));
      a = sample(); total++;
      if ((a & m) !== (e & m)) begin
        bad++; $display("FAIL err_hold[%0d]: got %h want %h", i, a, e);
      end
    end
    #2 reset = 1'b0;
    #1;
    e = idle_exp(); a = sample(); total++;
    if (a !== e) begin
      bad++; $display("FAIL err_reset: got %h want %h", a, e);
    end
    @(negedge clk);
    reset = 1'b1; instr_valid = 1'b0;
    apply(1'b1, OP_ADD, 1'b0);
    model_fetch(1'b1, OP_ADD, e, m, kind);
    a = sample(); total++;
    if ((a & m) !== (e & m)) begin
      bad++; $display("FAIL fetch_after_err: got %h want %h", a, e);
    end
`else
    // Without the timeout feature the access simply waits far past TO.
    run_mem(1'b0, 5 * TO);
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_ld_wait3();
    test_st_fast();
    test_random();
    test_reset_mid_mem();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
